// File: rtl/md5_pkg.sv
// rtl/md5_pkg.sv - MD5 constants, state type and step helper functions
// Purpose: shared definitions for the iterative MD5 core.
// Ports: none (package). Provides md5_state_t, MD5_IV, K/S tables,
// round function md5_f, word index md5_g, shift md5_s and md5_add.
package md5_pkg;

  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } core_state_t;

  // Packed so that {a,b,c,d} maps directly onto the 128-bit digest.
  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
    logic [31:0] d;
  } md5_state_t;

  localparam md5_state_t MD5_IV = '{
    a: 32'h67452301, b: 32'hefcdab89, c: 32'h98badcfe, d: 32'h10325476
  };

  localparam logic [31:0] MD5_K [64] = '{
    32'hd76aa478, 32'he8c7b756, 32'h242070db, 32'hc1bdceee,
    32'hf57c0faf, 32'h4787c62a, 32'ha8304613, 32'hfd469501,
    32'h698098d8, 32'h8b44f7af, 32'hffff5bb1, 32'h895cd7be,
    32'h6b901122, 32'hfd987193, 32'ha679438e, 32'h49b40821,
    32'hf61e2562, 32'hc040b340, 32'h265e5a51, 32'he9b6c7aa,
    32'hd62f105d, 32'h02441453, 32'hd8a1e681, 32'he7d3fbc8,
    32'h21e1cde6, 32'hc33707d6, 32'hf4d50d87, 32'h455a14ed,
    32'ha9e3e905, 32'hfcefa3f8, 32'h676f02d9, 32'h8d2a4c8a,
    32'hfffa3942, 32'h8771f681, 32'h6d9d6122, 32'hfde5380c,
    32'ha4beea44, 32'h4bdecfa9, 32'hf6bb4b60, 32'hbebfbc70,
    32'h289b7ec6, 32'heaa127fa, 32'hd4ef3085, 32'h04881d05,
    32'hd9d4d039, 32'he6db99e5, 32'h1fa27cf8, 32'hc4ac5665,
    32'hf4292244, 32'h432aff97, 32'hab9423a7, 32'hfc93a039,
    32'h655b59c3, 32'h8f0ccc92, 32'hffeff47d, 32'h85845dd1,
    32'h6fa87e4f, 32'hfe2ce6e0, 32'ha3014314, 32'h4e0811a1,
    32'hf7537e82, 32'hbd3af235, 32'h2ad7d2bb, 32'heb86d391
  };

  function automatic logic [31:0] md5_k(input logic [5:0] i);
    return MD5_K[i];
  endfunction

  // Shift amount depends only on the round and on i mod 4.
  function automatic logic [4:0] md5_s(input logic [5:0] i);
    case ({i[5:4], i[1:0]})
      4'h0: return 5'd7;
      4'h1: return 5'd12;
      4'h2: return 5'd17;
      4'h3: return 5'd22;
      4'h4: return 5'd5;
      4'h5: return 5'd9;
      4'h6: return 5'd14;
      4'h7: return 5'd20;
      4'h8: return 5'd4;
      4'h9: return 5'd11;
      4'ha: return 5'd16;
      4'hb: return 5'd23;
      4'hc: return 5'd6;
      4'hd: return 5'd10;
      4'he: return 5'd15;
      default: return 5'd21;
    endcase
  endfunction

  function automatic logic [31:0] md5_f(input logic [1:0] round, input logic [31:0] b,
                                        input logic [31:0] c, input logic [31:0] d);
    case (round)
      2'd0: return (b & c) | (~b & d);
      2'd1: return (d & b) | (~d & c);
      2'd2: return b ^ c ^ d;
      default: return c ^ (b | ~d);
    endcase
  endfunction

  // Only the low 4 bits of i matter once the result is taken mod 16.
  function automatic logic [3:0] md5_g(input logic [5:0] i);
    logic [3:0] l;
    l = i[3:0];
    case (i[5:4])
      2'd0: return l;
      2'd1: return l * 4'd5 + 4'd1;
      2'd2: return l * 4'd3 + 4'd5;
      default: return l * 4'd7;
    endcase
  endfunction

  function automatic md5_state_t md5_add(input md5_state_t x, input md5_state_t y);
    return '{a: x.a + y.a, b: x.b + y.b, c: x.c + y.c, d: x.d + y.d};
  endfunction

endpackage

// File: rtl/md5_iter_core_if.sv
// rtl/md5_iter_core_if.sv - block input / digest output bundle of the MD5 core
// Purpose: groups the block handshake and the digest outputs.
// Ports: blk_valid_i/blk_ready_o handshake, blk_first_i/blk_last_i qualifiers,
// blk_i 512-bit block, digest_o 128-bit digest, digest_valid_o pulse, busy_o.
// Modports: master drives blocks, slave is the core.
interface md5_iter_core_if;
  logic         blk_valid_i;
  logic         blk_ready_o;
  logic         blk_first_i;
  logic         blk_last_i;
  logic [511:0] blk_i;
  logic [127:0] digest_o;
  logic         digest_valid_o;
  logic         busy_o;

  modport master (
    output blk_valid_i, blk_first_i, blk_last_i, blk_i,
    input  blk_ready_o, digest_o, digest_valid_o, busy_o
  );

  modport slave (
    input  blk_valid_i, blk_first_i, blk_last_i, blk_i,
    output blk_ready_o, digest_o, digest_valid_o, busy_o
  );
endinterface

// File: rtl/md5_step.sv
// rtl/md5_step.sv - one combinational MD5 step
// Purpose: applies a single MD5 step to a working state.
// Ports: state_in working state, word M[g], k_const K[i], shift S[i],
// round (i/16), state_out next working state.
module md5_step
  import md5_pkg::*;
(
  input  md5_state_t  state_in,
  input  logic [31:0] word,
  input  logic [31:0] k_const,
  input  logic [4:0]  shift,
  input  logic [1:0]  round,
  output md5_state_t  state_out
);
  logic [31:0] f;
  logic [31:0] sum;
  logic [31:0] rot;

  assign f   = md5_f(round, state_in.b, state_in.c, state_in.d);
  assign sum = state_in.a + f + k_const + word;
  // shift is never 0 for MD5, so the right shift by 32-shift stays in range.
  assign rot = (sum << shift) | (sum >> (6'd32 - {1'b0, shift}));

  assign state_out = '{a: state_in.d, b: state_in.b + rot, c: state_in.b, d: state_in.c};
endmodule

// File: rtl/md5_iter_core.sv
// rtl/md5_iter_core.sv - iterative multi-block MD5 compression engine
// Purpose: hashes pre-padded 512-bit blocks, STEPS_PER_CLK steps per clock,
// chaining across blocks and publishing the digest after the last block.
// Ports: clk_i clock, rst_i async active-high reset, bus (slave modport)
// carrying the block handshake, qualifiers, digest and status.
module md5_iter_core
  import md5_pkg::*;
#(
  parameter int STEPS_PER_CLK = 1
) (
  input logic clk_i,
  input logic rst_i,
  md5_iter_core_if.slave bus
);
  if (STEPS_PER_CLK != 1 && STEPS_PER_CLK != 2 && STEPS_PER_CLK != 4) begin : g_bad_steps
    $error("md5_iter_core: STEPS_PER_CLK must be 1, 2 or 4");
  end

  localparam logic [5:0] LAST_CNT = 6'(64 - STEPS_PER_CLK);
  localparam logic [5:0] CNT_INC  = 6'(STEPS_PER_CLK);

  core_state_t  state, state_next;
  logic [5:0]   cnt;
  logic [511:0] blk;
  logic         last;
  logic         digest_valid;
  logic         accept, done;
  md5_state_t   work, chain, digest, final_work, chain_sum;

  // Unrolled step chain; instance k executes step cnt+k.
  for (genvar k = 0; k < STEPS_PER_CLK; k++) begin : g_step
    logic [5:0]  idx;
    logic [3:0]  g;
    logic [31:0] word;
    md5_state_t  st_in, st_out;

    assign idx  = cnt + 6'(k);
    assign g    = md5_g(idx);
    assign word = blk[{g, 5'd0} +: 32];

    if (k == 0) begin : g_head
      assign st_in = work;
    end else begin : g_tail
      assign st_in = g_step[k-1].st_out;
    end

    md5_step u_step (
      .state_in (st_in),
      .word     (word),
      .k_const  (md5_k(idx)),
      .shift    (md5_s(idx)),
      .round    (idx[5:4]),
      .state_out(st_out)
    );
  end

  assign final_work = g_step[STEPS_PER_CLK-1].st_out;
  assign chain_sum  = md5_add(chain, final_work);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    done       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.blk_valid_i) begin
          accept     = 1'b1;
          state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        if (cnt == LAST_CNT) begin
          done       = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt          <= '0;
      blk          <= '0;
      last         <= 1'b0;
      work         <= '0;
      chain        <= MD5_IV;
      digest       <= '0;
      digest_valid <= 1'b0;
    end else begin
      digest_valid <= 1'b0;
      if (accept) begin
        blk  <= bus.blk_i;
        last <= bus.blk_last_i;
        cnt  <= '0;
        // A first block restarts the message, dropping any partial chain.
        if (bus.blk_first_i) begin
          work  <= MD5_IV;
          chain <= MD5_IV;
        end else begin
          work <= chain;
        end
      end else if (state == ST_RUN) begin
        work <= final_work;
        cnt  <= cnt + CNT_INC;
        if (done) begin
          chain <= chain_sum;
          if (last) begin
            digest       <= chain_sum;
            digest_valid <= 1'b1;
          end
        end
      end
    end
  end

  assign bus.blk_ready_o    = (state == ST_IDLE);
  assign bus.busy_o         = (state == ST_RUN);
  assign bus.digest_o       = digest;
  assign bus.digest_valid_o = digest_valid;
endmodule

// File: tb/tb_md5_iter_core.sv
// tb/tb_md5_iter_core.sv - self-checking bench for md5_iter_core (S = 1, 2, 4)
module tb_md5_iter_core;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         valid = 1'b0, first_r = 1'b0, last_r = 1'b0;
  logic [511:0] blk_r = '0;
  logic [2:0]   rdy, bsy, dv;
  logic [2:0][127:0] dg;

  int total = 0, passed = 0, failed = 0;
  logic [31:0] kt [64];
  int rt [64];
  int sh [4][4] = '{'{7, 12, 17, 22}, '{5, 9, 14, 20}, '{4, 11, 16, 23}, '{6, 10, 15, 21}};

  localparam logic [127:0] IV_H      = 128'h67452301_efcdab89_98badcfe_10325476;
  localparam logic [127:0] DIG_EMPTY = 128'hd98c1dd4_04b2008f_980980e9_7e42f8ec;
  localparam logic [127:0] DIG_ABC   = 128'h98500190_b04fd23c_7d3f96d6_727fe128;
  localparam logic [127:0] DIG_80    = 128'ha2f4ed57_55c9e32b_2eda49ac_7ab60721;

  always #5 clk = ~clk;

  for (genvar k = 0; k < 3; k++) begin : g_dut
    md5_iter_core_if bus ();
    assign bus.blk_valid_i = valid;
    assign bus.blk_first_i = first_r;
    assign bus.blk_last_i  = last_r;
    assign bus.blk_i       = blk_r;
    assign rdy[k] = bus.blk_ready_o;
    assign bsy[k] = bus.busy_o;
    assign dv[k]  = bus.digest_valid_o;
    assign dg[k]  = bus.digest_o;
    md5_iter_core #(.STEPS_PER_CLK(1 << k)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));
  end

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) passed++;
    else begin failed++; $error("FAIL %s: observed %b expected %b", tag, obs, exp); end
  endtask

  task automatic check_num(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) passed++;
    else begin failed++; $error("FAIL %s: observed %0d expected %0d", tag, obs, exp); end
  endtask

  task automatic check_dig(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin failed++; $error("FAIL %s: observed %h expected %h", tag, obs, exp); end
  endtask

  // Straight RFC 1321 compression of one block.
  function automatic logic [127:0] md5_ref(input logic [127:0] h, input logic [511:0] m);
    logic [31:0] a, b, c, d, f, t;
    int g;
    {a, b, c, d} = h;
    for (int i = 0; i < 64; i++) begin
      case (i / 16)
        0: begin f = (b & c) | (~b & d); g = i; end
        1: begin f = (d & b) | (~d & c); g = (5 * i + 1) % 16; end
        2: begin f = b ^ c ^ d; g = (3 * i + 5) % 16; end
        default: begin f = c ^ (b | ~d); g = (7 * i) % 16; end
      endcase
      t = a + f + kt[i] + m[32*g +: 32];
      t = (t << rt[i]) | (t >> (32 - rt[i]));
      a = d; d = c; c = b; b = b + t;
    end
    return {h[127:96] + a, h[95:64] + b, h[63:32] + c, h[31:0] + d};
  endfunction

  function automatic logic [511:0] rand_blk();
    logic [511:0] b;
    for (int w = 0; w < 16; w++) b[32*w +: 32] = $urandom;
    return b;
  endfunction

  // Offers one block to DUT k, scrambles the block inputs while it runs,
  // and returns once busy drops (lat = cycles of busy, pulses = early strobes).
  task automatic do_block(input int k, input logic first, input logic last, input logic [511:0] b,
                          output int lat, output int pulses);
    int guard;
    valid = 1'b1; first_r = first; last_r = last; blk_r = b;
    guard = 0;
    while (!rdy[k] && guard < 400) begin @(posedge clk); #1; guard++; end
    @(posedge clk); #1;
    valid = 1'b0;
    lat = 0; pulses = 0;
    while (bsy[k] && lat < 400) begin
      blk_r = rand_blk(); first_r = 1'($urandom); last_r = 1'($urandom);
      pulses += int'(dv[k]);
      @(posedge clk); #1;
      lat++;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [511:0] b_empty, b_abc, b1, b2, rb;
    logic [1023:0] msg;
    logic [127:0]  chain;
    int lat, pulses, nb, guard;
    logic stable;

    for (int i = 0; i < 64; i++) begin
      real x;
      x = $sin(real'(i + 1));
      if (x < 0.0) x = -x;
      kt[i] = 32'(longint'($floor(x * 4294967296.0)));
      rt[i] = sh[i / 16][i % 4];
    end
    b_empty = '0; b_empty[31:0] = 32'h00000080;
    b_abc = '0; b_abc[31:0] = 32'h80636261; b_abc[14*32 +: 32] = 32'h00000018;
    msg = '0;
    for (int j = 0; j < 80; j++) msg[8*j +: 8] = 8'(8'h30 + (j + 1) % 10);
    msg[8*80 +: 8] = 8'h80; msg[8*120 +: 8] = 8'h80; msg[8*121 +: 8] = 8'h02;
    b1 = msg[511:0]; b2 = msg[1023:512];

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check_bit($sformatf("reset ready k%0d", k), rdy[k], 1'b1);
      check_bit($sformatf("reset busy k%0d", k), bsy[k], 1'b0);
      check_bit($sformatf("reset dvalid k%0d", k), dv[k], 1'b0);
      check_dig($sformatf("reset digest k%0d", k), dg[k], '0);
    end

    // Empty message, one step per clock.
    do_block(0, 1'b1, 1'b1, b_empty, lat, pulses);
    check_num("empty latency", lat, 64);
    check_num("empty early pulses", pulses, 0);
    check_bit("empty dvalid", dv[0], 1'b1);
    check_bit("empty ready back", rdy[0], 1'b1);
    check_dig("empty digest", dg[0], DIG_EMPTY);
    @(posedge clk); #1;
    check_bit("empty dvalid one cycle", dv[0], 1'b0);
    check_dig("empty digest held", dg[0], DIG_EMPTY);

    // "abc", four steps per clock.
    do_block(2, 1'b1, 1'b1, b_abc, lat, pulses);
    check_num("abc latency s4", lat, 16);
    check_bit("abc dvalid s4", dv[2], 1'b1);
    check_dig("abc digest s4", dg[2], DIG_ABC);

    // Two-block message back to back with valid held, two steps per clock.
    valid = 1'b1; first_r = 1'b1; last_r = 1'b0; blk_r = b1;
    guard = 0;
    while (!rdy[1] && guard < 400) begin @(posedge clk); #1; guard++; end
    @(posedge clk); #1;
    first_r = 1'b0; last_r = 1'b1; blk_r = b2;
    lat = 0; pulses = 0;
    while (bsy[1] && lat < 400) begin
      pulses += int'(dv[1]);
      @(posedge clk); #1;
      lat++;
    end
    check_num("b2b blk1 latency", lat, 32);
    check_num("b2b blk1 pulses", pulses + int'(dv[1]), 0);
    check_bit("b2b ready returns", rdy[1], 1'b1);
    @(posedge clk); #1;
    check_bit("b2b second accept", bsy[1], 1'b1);
    valid = 1'b0;
    lat = 0;
    while (bsy[1] && lat < 400) begin @(posedge clk); #1; lat++; end
    check_num("b2b blk2 latency", lat, 32);
    check_bit("b2b dvalid", dv[1], 1'b1);
    check_dig("b2b digest", dg[1], DIG_80);

    // Random multi-block messages against the model on every core.
    for (int k = 0; k < 3; k++) begin
      for (int n = 0; n < 2; n++) begin
        nb = $urandom_range(1, 3);
        chain = IV_H;
        for (int bi = 0; bi < nb; bi++) begin
          rb = rand_blk();
          chain = md5_ref(chain, rb);
          do_block(k, bi == 0, bi == nb - 1, rb, lat, pulses);
          check_num($sformatf("rand latency k%0d", k), lat, 64 >> k);
          check_bit($sformatf("rand dvalid k%0d b%0d", k, bi), dv[k], bi == nb - 1);
        end
        check_dig($sformatf("rand digest k%0d m%0d", k, n), dg[k], chain);
      end
    end

    // Abandoned message, then a fresh "abc".
    do_block(0, 1'b1, 1'b0, rand_blk(), lat, pulses);
    check_bit("abandon no pulse", dv[0], 1'b0);
    do_block(0, 1'b1, 1'b1, b_abc, lat, pulses);
    check_dig("abandon abc digest", dg[0], DIG_ABC);

    // Idle with valid low: stays ready, digest stable.
    stable = 1'b1;
    repeat (40) begin
      @(posedge clk); #1;
      if (rdy[0] !== 1'b1 || bsy[0] !== 1'b0 || dg[0] !== DIG_ABC) stable = 1'b0;
    end
    check_bit("idle stable", stable, 1'b1);

    // Reset at step 30 of an "abc" run.
    valid = 1'b1; first_r = 1'b1; last_r = 1'b1; blk_r = b_abc;
    guard = 0;
    while (!rdy[0] && guard < 400) begin @(posedge clk); #1; guard++; end
    @(posedge clk); #1;
    valid = 1'b0;
    repeat (30) begin @(posedge clk); #1; end
    check_bit("pre-reset busy", bsy[0], 1'b1);
    rst = 1'b1;
    #1;
    check_bit("midrun reset ready", rdy[0], 1'b1);
    check_bit("midrun reset busy", bsy[0], 1'b0);
    check_bit("midrun reset dvalid", dv[0], 1'b0);
    check_dig("midrun reset digest", dg[0], '0);
    @(posedge clk); #1;
    rst = 1'b0;
    pulses = 0;
    repeat (70) begin @(posedge clk); #1; pulses += int'(dv[0]); end
    check_num("midrun reset no pulse", pulses, 0);
    do_block(0, 1'b0, 1'b1, b_empty, lat, pulses);
    check_dig("post-reset chain from iv", dg[0], DIG_EMPTY);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/md5_iter_core.md
# md5_iter_core

Parametrised iterative MD5 compression engine. Accepts pre-padded 512-bit message blocks over a valid/ready handshake and chains them across multi-block messages. It executes `STEPS_PER_CLK` of the 64 MD5 steps per clock and emits the 128-bit digest after the last block. It replaces the fixed single-round, fixed-IV MD5 datapath and is the hashing core of the MD5 designs.

## Interface
- `STEPS_PER_CLK`, default 1: MD5 steps per clock. Legal values are 1, 2, 4; any other value is an elaboration error.
- `clk_i` in 1: the single clock. All state updates on the rising edge.
- `rst_i` in 1: reset, asynchronous and active-high.
- `blk_valid_i` in 1: a block is offered.
- `blk_ready_o` out 1: the core can accept a block. High only in IDLE.
- `blk_first_i` in 1: qualifies the block. 1 = reload the chaining state from the IV before this block.
- `blk_last_i` in 1: qualifies the block. 1 = publish the digest after this block.
- `blk_i` in 512: message words. M[j] = `blk_i[32j+31:32j]`, little-endian words, padding and length already applied.
- `digest_o` out 128: {A,B,C,D} = {`[127:96]`,…,`[31:0]`}, final chaining words.
- `digest_valid_o` out 1: one-cycle pulse when `digest_o` updates.
- `busy_o` out 1: high in RUN.

## Operation
- States: IDLE, RUN.
- IDLE → RUN on `blk_valid_i & blk_ready_o` (accept):
  - Capture the block.
  - Load the working regs a,b,c,d from the IV (67452301, EFCDAB89, 98BADCFE, 10325476) if `blk_first_i`, else from the chaining regs.
  - Latch `blk_last_i`.
  - Clear the step counter.
- RUN:
  - Each cycle applies steps s..s+`STEPS_PER_CLK`-1, then s += `STEPS_PER_CLK`.
  - Step i:
    - F = (b&c)|(~b&d) for i<16
    - (d&b)|(~d&c) for i<32
    - b^c^d for i<48
    - c^(b|~d) otherwise
  - Word index g = i, (5i+1), (3i+5), (7i) mod 16 for the four rounds.
  - new_b = b + rotl(a + F + K[i] + M[g], S[i]); (a,b,c,d) ← (d,new_b,b,c).
  - All additions are modulo 2^32. Carries are discarded.
- On the cycle that completes step 63:
  - Chaining regs ← chaining + working, per word, mod 2^32.
  - Return to IDLE.
  - If the latched last flag is set, `digest_o` ← the new chaining value and `digest_valid_o` pulses.
- A block without `blk_first_i` after reset chains from the IV, because reset loads the IV into the chaining regs.
- `blk_first_i` on a block following a non-last block abandons the old message silently.
- `digest_o` holds its value until the next last block completes. There is no back-pressure on the digest.

## Timing
- Reset values:
  - `blk_ready_o`=1, `busy_o`=0, `digest_valid_o`=0, `digest_o`=0.
  - Chaining = IV, step counter = 0, state IDLE.
- Block latency: N = 64/`STEPS_PER_CLK` cycles.
  - Accept at edge t0. `busy_o` is high for cycles t0+1..t0+N and `blk_ready_o` is low for the same cycles.
  - The digest is registered at edge t0+N. `digest_valid_o` is high during cycle t0+N..t0+N+1.
  - `blk_ready_o` is high again in that same cycle.
- Throughput: one block per N+1 cycles in back-to-back operation.
- `blk_i`, `blk_first_i`, and `blk_last_i` are sampled only at accept. Changes during RUN are ignored.
- `blk_valid_i` held high in IDLE is accepted on the first edge. Holding it during RUN has no effect.
- Reset asserted mid-RUN takes effect asynchronously:
  - All regs return to their reset values.
  - The partial block is lost.
  - No `digest_valid_o` pulse.

## Structure
- `md5_pkg` holds:
  - K[0:63] (RFC 1321 constants), the shift table S[0:63], and the IV words.
  - The round-function and word-index functions.
  - A `md5_state_t` struct {a,b,c,d}.
- Sub-module `md5_step`: combinational single step (inputs: state, M[g], K[i], S[i], round; output: next state).
  - `md5_iter_core` chains `STEPS_PER_CLK` instances.
  - The step index for instance k is counter+k.
- Top-level parts: FSM, step counter, and chaining/digest registers.

## Test plan
- S=1, "" block (M[0]=00000080, all others 0): `digest_o`=d98c1dd4_04b2008f_980980e9_7e42f8ec (hex d41d8cd98f00b204e9800998ecf8427e). Pulse at exactly 64 cycles after accept.
- S=4, "abc" (M[0]=80636261, M[14]=00000018): digest hex 900150983cd24fb0d6963f7d28e17f72. Latency 16 cycles.
- S=2, 80-byte "1234567890"×8 as two blocks (first, then last), back-to-back with `blk_valid_i` held high:
  - Digest 57edf4a22be3c955ac49da2e2107b67a.
  - No pulse after block 1.
  - Second accept occurs in the cycle `blk_ready_o` returns.
- Abandon: first non-last block of a random message, then an "abc" block with first=1 and last=1 → "abc" digest.
- Reset at step 30 of an "abc" run:
  - All outputs return to reset values immediately.
  - No pulse.
  - A following "" block gives the empty digest.
- Protocol:
  - `blk_i` toggled randomly during RUN → digest unchanged.
  - `blk_valid_i` low → the core stays in IDLE indefinitely with `digest_o` stable.
